// File: rtl/snf_rxreq_if.sv
// CHI REQ flit type plus the link/memory-controller bundle seen by the SN-F receiver.
// The HN-F/MC side uses master; the receiver uses slave.
package snf_rxreq_pkg;
  typedef struct packed {
    logic [3:0]  qos;
    logic [6:0]  tgtid;
    logic [6:0]  srcid;
    logic [7:0]  txnid;
    logic [5:0]  opcode;
    logic [2:0]  size;
    logic [47:0] addr;
  } reqflit_t;

  localparam logic [5:0] OP_LCRDRETURN = 6'h00;
endpackage

interface snf_rxreq_if;
  import snf_rxreq_pkg::*;

  reqflit_t RXREQFLIT;
  logic     RXREQFLITV;
  logic     RXREQFLITPEND;
  logic     RXREQLCRDV;
  reqflit_t rxreqflit;
  logic     rxreq_valid;
  logic     rxreq_ready;

  modport master (
    output RXREQFLIT, RXREQFLITV, RXREQFLITPEND, rxreq_ready,
    input  RXREQLCRDV, rxreqflit, rxreq_valid
  );

  modport slave (
    input  RXREQFLIT, RXREQFLITV, RXREQFLITPEND, rxreq_ready,
    output RXREQLCRDV, rxreqflit, rxreq_valid
  );
endinterface

// File: rtl/snf_rxreq.sv
// SN-F CHI REQ receiver: grants link credits, buffers request flits in a DEPTH-entry
// FIFO for the memory controller, absorbs ReqLCrdReturn and flags uncredited flits.
module snf_rxreq
  import snf_rxreq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  snf_rxreq_if.slave    rx,
  output logic [CW-1:0] crd_cnt,
  output logic [CW-1:0] occupancy,
  output logic          err_no_credit
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] crd_q, crd_d, occ_q, occ_d;
  logic          lcrdv_q, lcrdv_d, err_q;
  logic [PW-1:0] wr_q, rd_q;
  reqflit_t      mem_q [DEPTH];
  logic          consume, push, pop, flit_bad;
  logic          unused_pend;

  assign unused_pend = rx.RXREQFLITPEND;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    consume  = rx.RXREQFLITV && (crd_q != '0);
    flit_bad = rx.RXREQFLITV && (crd_q == '0);
    push     = consume && (rx.RXREQFLIT.opcode != OP_LCRDRETURN);
    pop      = (occ_q != '0) && rx.rxreq_ready;
    crd_d    = crd_q + CW'(lcrdv_q) - CW'(consume);
    occ_d    = occ_q + CW'(push) - CW'(pop);
    // Grant while granted-but-unused credits plus held entries leave a free slot.
    lcrdv_d  = ({1'b0, crd_d} + {1'b0, occ_d}) < (CW+1)'(DEPTH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      crd_q   <= '0;
      occ_q   <= '0;
      lcrdv_q <= 1'b0;
      err_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      crd_q   <= crd_d;
      occ_q   <= occ_d;
      lcrdv_q <= lcrdv_d;
      if (flit_bad) err_q <= 1'b1;
      if (push)     wr_q  <= ptr_inc(wr_q);
      if (pop)      rd_q  <= ptr_inc(rd_q);
    end
  end

  // Storage carries no reset; only the pointers and counters define validity.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= rx.RXREQFLIT;
  end

  assign rx.RXREQLCRDV  = lcrdv_q;
  assign rx.rxreq_valid = (occ_q != '0);
  assign rx.rxreqflit   = mem_q[rd_q];
  assign crd_cnt        = crd_q;
  assign occupancy      = occ_q;
  assign err_no_credit  = err_q;

endmodule

// File: tb/tb_snf_rxreq.sv
// Directed bench for snf_rxreq: expected flits go into a scoreboard queue, a negedge
// monitor checks every accepted head; counters and credit pulses are checked inline.
module tb_snf_rxreq;
  import snf_rxreq_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic [CW-1:0] crd_cnt, occupancy;
  logic          err_no_credit;

  snf_rxreq_if bus ();

  snf_rxreq #(.DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .rx            (bus.slave),
    .crd_cnt       (crd_cnt),
    .occupancy     (occupancy),
    .err_no_credit (err_no_credit)
  );

  always #5 clock = ~clock;

  int       vec_cnt  = 0;
  int       miss_cnt = 0;
  reqflit_t exp_q [$];

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic reqflit_t mk(input logic [5:0] op, input logic [47:0] a, input logic [7:0] id);
    reqflit_t f;
    f        = '0;
    f.opcode = op;
    f.addr   = a;
    f.txnid  = id;
    f.srcid  = 7'h05;
    f.size   = 3'd6;
    return f;
  endfunction

  // Drive one flit for the current cycle; expect it downstream when it will be enqueued.
  task automatic send(input reqflit_t f, input bit expect_out);
    bus.RXREQFLIT  = f;
    bus.RXREQFLITV = 1'b1;
    if (expect_out) exp_q.push_back(f);
  endtask

  // Scoreboard monitor: every handshake on the head must match the oldest expected flit.
  always @(negedge clock) begin
    if (!reset && bus.rxreq_valid && bus.rxreq_ready) begin
      vec_cnt++;
      if (exp_q.size() == 0) begin
        miss_cnt++;
        $display("FAIL head_unexpected: got txnid %0h, expected nothing", bus.rxreqflit.txnid);
      end else begin
        reqflit_t e;
        e = exp_q.pop_front();
        if (bus.rxreqflit !== e) begin
          miss_cnt++;
          $display("FAIL head_flit: got op %0h addr %0h txnid %0h, expected op %0h addr %0h txnid %0h",
                   bus.rxreqflit.opcode, bus.rxreqflit.addr, bus.rxreqflit.txnid,
                   e.opcode, e.addr, e.txnid);
        end
      end
    end
  end

  initial begin
    reset             = 1'b1;
    bus.RXREQFLIT     = '0;
    bus.RXREQFLITV    = 1'b0;
    bus.RXREQFLITPEND = 1'b0;
    bus.rxreq_ready   = 1'b0;
    repeat (3) tick();

    chk("rst_lcrdv", int'(bus.RXREQLCRDV), 0);
    chk("rst_crd",   int'(crd_cnt), 0);
    chk("rst_occ",   int'(occupancy), 0);
    chk("rst_valid", int'(bus.rxreq_valid), 0);
    chk("rst_err",   int'(err_no_credit), 0);

    // 1: post-reset credit burst, high exactly cycles 1..DEPTH after release
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("boot_lcrdv_c%0d", k), int'(bus.RXREQLCRDV), (k <= DEPTH) ? 1 : 0);
      chk($sformatf("boot_crd_c%0d", k), int'(crd_cnt), (k <= DEPTH) ? k - 1 : DEPTH);
    end
    chk("boot_occ", int'(occupancy), 0);

    // 2: single ReadNoSnp, popped immediately, credit back one cycle later
    bus.rxreq_ready = 1'b1;
    send(mk(6'h04, 48'h1000, 8'h12), 1'b1);
    tick();
    bus.RXREQFLITV = 1'b0;
    chk("t2_valid", int'(bus.rxreq_valid), 1);
    chk("t2_crd",   int'(crd_cnt), 3);
    chk("t2_lcrdv_hold", int'(bus.RXREQLCRDV), 0);
    tick();
    chk("t2_lcrdv_pulse", int'(bus.RXREQLCRDV), 1);
    chk("t2_occ", int'(occupancy), 0);
    tick();
    chk("t2_lcrdv_done", int'(bus.RXREQLCRDV), 0);
    chk("t2_crd_back", int'(crd_cnt), 4);

    // 3: fill the FIFO with ready low
    bus.rxreq_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send(mk(6'h04, 48'h2000 + 48'(i * 64), 8'(i)), 1'b1);
      tick();
      chk($sformatf("t3_lcrdv_%0d", i), int'(bus.RXREQLCRDV), 0);
    end
    bus.RXREQFLITV = 1'b0;
    tick();
    chk("t3_occ_full", int'(occupancy), 4);
    chk("t3_crd_zero", int'(crd_cnt), 0);
    chk("t3_lcrdv_idle", int'(bus.RXREQLCRDV), 0);

    // 4: pop one, regain a credit, then push TxnID 5 alongside the next pop
    bus.rxreq_ready = 1'b1;
    tick();
    bus.rxreq_ready = 1'b0;
    chk("t4_occ_after_pop", int'(occupancy), 3);
    chk("t4_lcrdv_pulse", int'(bus.RXREQLCRDV), 1);
    tick();
    chk("t4_crd_regained", int'(crd_cnt), 1);
    chk("t4_lcrdv_low", int'(bus.RXREQLCRDV), 0);
    bus.rxreq_ready = 1'b1;
    send(mk(6'h04, 48'h3000, 8'h05), 1'b1);
    tick();
    bus.RXREQFLITV = 1'b0;
    chk("t4_occ_pushpop", int'(occupancy), 3);
    chk("t4_crd_used", int'(crd_cnt), 0);
    chk("t4_lcrdv_pop", int'(bus.RXREQLCRDV), 1);
    repeat (6) tick();
    chk("t4_occ_drained", int'(occupancy), 0);
    chk("t4_crd_full", int'(crd_cnt), 4);
    chk("t4_lcrdv_end", int'(bus.RXREQLCRDV), 0);

    // 5: ReqLCrdReturn consumes a credit without enqueueing
    send(mk(6'h00, 48'h0, 8'h00), 1'b0);
    tick();
    bus.RXREQFLITV = 1'b0;
    chk("t5_crd", int'(crd_cnt), 3);
    chk("t5_occ", int'(occupancy), 0);
    chk("t5_valid", int'(bus.rxreq_valid), 0);
    chk("t5_lcrdv_pulse", int'(bus.RXREQLCRDV), 1);
    tick();
    chk("t5_lcrdv_done", int'(bus.RXREQLCRDV), 0);
    chk("t5_crd_back", int'(crd_cnt), 4);

    // 6: flit in the first credit cycle is dropped and latches the error
    bus.rxreq_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("t6_first_lcrdv", int'(bus.RXREQLCRDV), 1);
    send(mk(6'h04, 48'h4000, 8'h66), 1'b0);
    tick();
    bus.RXREQFLITV = 1'b0;
    chk("t6_err_set", int'(err_no_credit), 1);
    chk("t6_dropped_occ", int'(occupancy), 0);
    chk("t6_crd_first", int'(crd_cnt), 1);
    repeat (4) tick();
    chk("t6_err_sticky", int'(err_no_credit), 1);
    chk("t6_crd_refill", int'(crd_cnt), 4);

    // Buffer two flits then reset: contents discarded, error cleared
    send(mk(6'h04, 48'h5000, 8'h21), 1'b0);
    tick();
    send(mk(6'h04, 48'h5040, 8'h22), 1'b0);
    tick();
    bus.RXREQFLITV = 1'b0;
    chk("t6_occ_two", int'(occupancy), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_occ", int'(occupancy), 0);
    chk("t6_rst_valid", int'(bus.rxreq_valid), 0);
    chk("t6_rst_err", int'(err_no_credit), 0);
    chk("t6_rst_crd", int'(crd_cnt), 0);
    chk("t6_rst_lcrdv", int'(bus.RXREQLCRDV), 0);
    tick();
    chk("t6_restart_lcrdv", int'(bus.RXREQLCRDV), 1);

    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
